// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - TL-UL channel structs and opcodes used by the copy engine
package tlul_pkg;

    localparam logic [2:0] PutFullData   = 3'h0;
    localparam logic [2:0] Get           = 3'h4;
    localparam logic [2:0] AccessAck     = 3'h0;
    localparam logic [2:0] AccessAckData = 3'h1;

    localparam logic [6:0] A_USER_DEFAULT = 7'h0;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [6:0]  a_user;
        logic        d_ready;
    } tlul_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [6:0]  d_user;
        logic        d_error;
        logic        a_ready;
    } tlul_d2h_t;

endpackage

// File: rtl/tlul_mem_copy.sv
// rtl/tlul_mem_copy.sv - TL-UL host that copies a run of words with one Get/Put outstanding
module tlul_mem_copy #(
    parameter int unsigned LenW     = 13,
    parameter logic [7:0]  SourceId = 8'h0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    output tlul_pkg::tlul_h2d_t  tl_o,
    input  tlul_pkg::tlul_d2h_t  tl_i,
    input  logic                 start_i,
    input  logic [31:0]          src_addr_i,
    input  logic [31:0]          dst_addr_i,
    input  logic [LenW-1:0]      len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [LenW-1:0]      words_done_o
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] WR_WAIT = 3'd4;
    localparam logic [2:0] FINISH  = 3'd5;

    logic [2:0]      state_q, state_d;
    logic [31:0]     src_q, src_d;
    logic [31:0]     dst_q, dst_d;
    logic [LenW-1:0] len_q, len_d;
    logic [LenW-1:0] words_q, words_d;
    logic            err_q, err_d;

    // A channel is fully registered so fields stay stable through a stall.
    logic            a_valid_q, a_valid_d;
    logic [2:0]      a_opcode_q, a_opcode_d;
    logic [1:0]      a_size_q, a_size_d;
    logic [3:0]      a_mask_q, a_mask_d;
    logic [31:0]     a_address_q, a_address_d;
    logic [31:0]     a_data_q, a_data_d;

    logic            last_word;
    logic [31:0]     src_next, dst_next;

    assign last_word = (words_q + LenW'(1)) == len_q;
    assign src_next  = src_q + 32'd4;
    assign dst_next  = dst_q + 32'd4;

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        len_d       = len_q;
        words_d     = words_q;
        err_d       = err_q;
        a_valid_d   = a_valid_q;
        a_opcode_d  = a_opcode_q;
        a_size_d    = a_size_q;
        a_mask_d    = a_mask_q;
        a_address_d = a_address_q;
        a_data_d    = a_data_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    src_d   = {src_addr_i[31:2], 2'b00};
                    dst_d   = {dst_addr_i[31:2], 2'b00};
                    len_d   = len_i;
                    err_d   = 1'b0;
                    words_d = '0;
                    if (len_i != '0) begin
                        state_d     = RD_REQ;
                        a_valid_d   = 1'b1;
                        a_opcode_d  = tlul_pkg::Get;
                        a_size_d    = 2'd2;
                        a_mask_d    = 4'hF;
                        a_address_d = {src_addr_i[31:2], 2'b00};
                        a_data_d    = '0;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            RD_REQ: begin
                if (tl_i.a_ready) begin
                    state_d   = RD_WAIT;
                    a_valid_d = 1'b0;
                end
            end
            RD_WAIT: begin
                if (tl_i.d_valid) begin
                    if (tl_i.d_error) begin
                        err_d   = 1'b1;
                        state_d = FINISH;
                    end else begin
                        // a_data_q doubles as the holding register for the read word.
                        state_d     = WR_REQ;
                        a_valid_d   = 1'b1;
                        a_opcode_d  = tlul_pkg::PutFullData;
                        a_address_d = dst_q;
                        a_data_d    = tl_i.d_data;
                    end
                end
            end
            WR_REQ: begin
                if (tl_i.a_ready) begin
                    state_d   = WR_WAIT;
                    a_valid_d = 1'b0;
                end
            end
            WR_WAIT: begin
                if (tl_i.d_valid) begin
                    if (tl_i.d_error) begin
                        err_d   = 1'b1;
                        state_d = FINISH;
                    end else begin
                        words_d = words_q + LenW'(1);
                        src_d   = src_next;
                        dst_d   = dst_next;
                        if (last_word) begin
                            state_d = FINISH;
                        end else begin
                            state_d     = RD_REQ;
                            a_valid_d   = 1'b1;
                            a_opcode_d  = tlul_pkg::Get;
                            a_address_d = src_next;
                            a_data_d    = '0;
                        end
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                a_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            words_q     <= '0;
            err_q       <= 1'b0;
            a_valid_q   <= 1'b0;
            a_opcode_q  <= '0;
            a_size_q    <= '0;
            a_mask_q    <= '0;
            a_address_q <= '0;
            a_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            words_q     <= words_d;
            err_q       <= err_d;
            a_valid_q   <= a_valid_d;
            a_opcode_q  <= a_opcode_d;
            a_size_q    <= a_size_d;
            a_mask_q    <= a_mask_d;
            a_address_q <= a_address_d;
            a_data_q    <= a_data_d;
        end
    end

    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = a_valid_q;
        tl_o.a_opcode  = a_opcode_q;
        tl_o.a_param   = 3'h0;
        tl_o.a_size    = a_size_q;
        tl_o.a_source  = SourceId;
        tl_o.a_address = a_address_q;
        tl_o.a_mask    = a_mask_q;
        tl_o.a_data    = a_data_q;
        tl_o.a_user    = tlul_pkg::A_USER_DEFAULT;
        tl_o.d_ready   = 1'b1;
    end

    // Response fields the engine does not interpret.
    logic unused_d;
    assign unused_d = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source,
                        tl_i.d_sink, tl_i.d_user};

    assign busy_o       = state_q != IDLE;
    assign done_o       = state_q == FINISH;
    assign err_o        = err_q;
    assign words_done_o = words_q;

endmodule

// File: tb/tb_tlul_mem_copy.sv
// tb/tb_tlul_mem_copy.sv - scoreboard bench for tlul_mem_copy against a simple memory device
module tb_tlul_mem_copy;

    localparam int LenW = 13;

    typedef struct {
        logic [2:0]  opcode;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic start_i = 1'b0;
    logic [31:0] src_addr_i = '0;
    logic [31:0] dst_addr_i = '0;
    logic [LenW-1:0] len_i = '0;
    logic busy_o, done_o, err_o;
    logic [LenW-1:0] words_done_o;
    tlul_pkg::tlul_h2d_t tl_h2d;
    tlul_pkg::tlul_d2h_t dev = '0;

    int n_vec = 0;
    int n_err = 0;

    txn_t exp_q[$];
    logic [31:0] mem [logic [31:0]];

    int stall_cfg = 0;
    logic err_en = 1'b0;
    logic [31:0] err_addr = '0;
    int hs_count = 0;

    always #5 clk = ~clk;

    tlul_mem_copy #(.LenW(LenW), .SourceId(8'h0)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .tl_o         (tl_h2d),
        .tl_i         (dev),
        .start_i      (start_i),
        .src_addr_i   (src_addr_i),
        .dst_addr_i   (dst_addr_i),
        .len_i        (len_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .words_done_o (words_done_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Device model: decides a_ready at the negedge, answers one cycle after the handshake.
    int wait_cnt = 0;
    logic pend = 1'b0, pend_err = 1'b0, hs_prev = 1'b0;
    logic [31:0] pend_data = '0;
    tlul_pkg::tlul_h2d_t saved;

    always @(negedge clk) begin
        if (!rst_ni) begin
            dev = '0;
            pend = 1'b0;
            wait_cnt = 0;
            hs_prev = 1'b0;
        end else begin
            if (hs_prev) check_eq("a_valid_after_hs", 32'(tl_h2d.a_valid), 32'd0);
            hs_prev = 1'b0;
            dev.d_valid = pend;
            dev.d_data = pend_data;
            dev.d_error = pend_err;
            dev.d_opcode = tlul_pkg::AccessAckData;
            pend = 1'b0;
            dev.a_ready = 1'b0;
            if (tl_h2d.a_valid) begin
                if (wait_cnt > 0) begin
                    check_eq("stall_addr", tl_h2d.a_address, saved.a_address);
                    check_eq("stall_data", tl_h2d.a_data, saved.a_data);
                    check_eq("stall_opcode", 32'(tl_h2d.a_opcode), 32'(saved.a_opcode));
                end else begin
                    saved = tl_h2d;
                end
                if (wait_cnt >= stall_cfg) begin
                    txn_t e;
                    dev.a_ready = 1'b1;
                    hs_prev = 1'b1;
                    wait_cnt = 0;
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        check_eq("txn_extra", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("txn_opcode", 32'(tl_h2d.a_opcode), 32'(e.opcode));
                        check_eq("txn_addr", tl_h2d.a_address, e.addr);
                        check_eq("txn_data", tl_h2d.a_data, e.data);
                        check_eq("txn_mask", 32'(tl_h2d.a_mask), 32'hF);
                        check_eq("txn_size", 32'(tl_h2d.a_size), 32'd2);
                        check_eq("txn_source", 32'(tl_h2d.a_source), 32'd0);
                    end
                    pend = 1'b1;
                    if (tl_h2d.a_opcode == tlul_pkg::Get) begin
                        pend_data = mem.exists(tl_h2d.a_address) ? mem[tl_h2d.a_address] : 32'h0;
                        pend_err = err_en && (tl_h2d.a_address == err_addr);
                    end else begin
                        mem[tl_h2d.a_address] = tl_h2d.a_data;
                        pend_data = '0;
                        pend_err = 1'b0;
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    task automatic push_expected(input logic [31:0] src, input logic [31:0] dst,
                                 input int len, input int err_word);
        txn_t t;
        for (int i = 0; i < len; i++) begin
            t.opcode = tlul_pkg::Get;
            t.addr = src + 32'(4 * i);
            t.data = 32'h0;
            exp_q.push_back(t);
            if (err_word == i + 1) break;
            t.opcode = tlul_pkg::PutFullData;
            t.addr = dst + 32'(4 * i);
            t.data = mem.exists(src + 32'(4 * i)) ? mem[src + 32'(4 * i)] : 32'h0;
            exp_q.push_back(t);
        end
    endtask

    task automatic run_copy(input string tag, input logic [31:0] src, input logic [31:0] dst,
                            input int len, input int stall, input int err_word, input bit poke,
                            input int exp_cyc, input int exp_words, input int exp_err);
        logic [31:0] fs, fd;
        int cyc;
        fs = {src[31:2], 2'b00};
        fd = {dst[31:2], 2'b00};
        stall_cfg = stall;
        err_en = (err_word != 0);
        err_addr = fs + 32'(4 * (err_word - 1));
        push_expected(fs, fd, len, err_word);
        @(negedge clk);
        src_addr_i = src;
        dst_addr_i = dst;
        len_i = LenW'(len);
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 2) begin
                src_addr_i = 32'h3000_0000;
                dst_addr_i = 32'h3000_0100;
                len_i = LenW'(7);
                start_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
        end while (!done_o && cyc < 2000);
        start_i = 1'b0;
        check_eq({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
        check_eq({tag, "_err"}, 32'(err_o), 32'(exp_err));
        check_eq({tag, "_words"}, 32'(words_done_o), 32'(exp_words));
        check_eq({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check_eq({tag, "_busy_after"}, 32'(busy_o), 32'd0);
        check_eq({tag, "_done_once"}, 32'(done_o), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int hs_before;
        #12;
        check_eq("rst_a_valid", 32'(tl_h2d.a_valid), 32'd0);
        check_eq("rst_d_ready", 32'(tl_h2d.d_ready), 32'd1);
        check_eq("rst_a_addr", tl_h2d.a_address, 32'd0);
        check_eq("rst_a_source", 32'(tl_h2d.a_source), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_done", 32'(done_o), 32'd0);
        check_eq("rst_err", 32'(err_o), 32'd0);
        check_eq("rst_words", 32'(words_done_o), 32'd0);
        @(negedge clk);
        #2 rst_ni = 1'b1;
        repeat (2) @(negedge clk);

        mem[32'h2000_0000] = 32'hDEAD_BEEF;
        run_copy("single", 32'h2000_0000, 32'h2000_0100, 1, 0, 0, 1'b0, 5, 1, 0);
        check_eq("single_dst", mem[32'h2000_0100], 32'hDEAD_BEEF);

        for (int i = 1; i < 4; i++) mem[32'h2000_0000 + 32'(4 * i)] = $urandom;
        run_copy("four", 32'h2000_0003, 32'h2000_0040, 4, 0, 0, 1'b0, 17, 4, 0);
        for (int i = 0; i < 4; i++)
            check_eq("four_dst", mem[32'h2000_0040 + 32'(4 * i)], mem[32'h2000_0000 + 32'(4 * i)]);

        for (int i = 0; i < 2; i++) mem[32'h2000_0200 + 32'(4 * i)] = 32'hA5A5_0000 + 32'(i);
        run_copy("stall", 32'h2000_0200, 32'h2000_0300, 2, 3, 0, 1'b0, 21, 2, 0);

        run_copy("rd_err", 32'h2000_0000, 32'h2000_0400, 4, 0, 2, 1'b0, 7, 1, 1);
        run_copy("err_clear", 32'h2000_0000, 32'h2000_0500, 1, 0, 0, 1'b0, 5, 1, 0);

        hs_before = hs_count;
        run_copy("len0", 32'h2000_0000, 32'h2000_0600, 0, 0, 0, 1'b0, 1, 0, 0);
        check_eq("len0_no_bus", 32'(hs_count - hs_before), 32'd0);

        run_copy("poke", 32'h2000_0200, 32'h2000_0700, 2, 0, 0, 1'b1, 9, 2, 0);

        // Reset while a write request is stalled.
        stall_cfg = 3;
        err_en = 1'b0;
        push_expected(32'h2000_0000, 32'h2000_0800, 2, 0);
        @(negedge clk);
        src_addr_i = 32'h2000_0000;
        dst_addr_i = 32'h2000_0800;
        len_i = LenW'(2);
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(tl_h2d.a_valid && tl_h2d.a_opcode == tlul_pkg::PutFullData) && n < 200);
            check_eq("rst_wr_reached", 32'(n < 200), 32'd1);
        end
        #2 rst_ni = 1'b0;
        #1;
        check_eq("midrst_a_valid", 32'(tl_h2d.a_valid), 32'd0);
        check_eq("midrst_busy", 32'(busy_o), 32'd0);
        check_eq("midrst_err", 32'(err_o), 32'd0);
        check_eq("midrst_words", 32'(words_done_o), 32'd0);
        exp_q.delete();
        @(negedge clk);
        #2 rst_ni = 1'b1;
        repeat (2) @(negedge clk);
        run_copy("post_rst", 32'h2000_0000, 32'h2000_0900, 1, 0, 0, 1'b0, 5, 1, 0);
        check_eq("post_rst_dst", mem[32'h2000_0900], 32'hDEAD_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
